ram_sync_param: RTL and testbench

- Parametrised single-port synchronous RAM with hardware zero-initialisation.
- Successor to the fixed 8x4 RAM.
- Adds configurable width and depth, selectable read-during-write mode, and an optional output register.
- Adds a read-valid strobe and a clear/initialise sweep FSM.
- Sits as the generic local storage primitive under buffers, lookup tables and register files.

---
 rtl/ram_sync_param_pkg.sv | 7 +
 rtl/ram_if.sv | 16 +
 rtl/ram_init_seq.sv | 34 +++
 rtl/ram_sync_param.sv | 62 ++++++
 tb/tb_ram_sync_param.sv | 118 +++++++++++
 5 files changed

// File: rtl/ram_sync_param_pkg.sv
// ram_sync_param_pkg: shared FSM encoding and read-during-write mode constants
package ram_sync_param_pkg;
  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN = 1'b1;
  localparam int RD_FIRST = 0;
  localparam int WR_FIRST = 1;
endpackage

// File: rtl/ram_if.sv
// ram_if: request/response bundle between a RAM user and ram_sync_param
interface ram_if #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 3
);
  logic clr;
  logic wr;
  logic rd;
  logic [ADDR_W-1:0] add;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic rd_valid;
  logic init_busy;
  modport master (output clr, wr, rd, add, data_in, input data_out, rd_valid, init_busy);
  modport slave (input clr, wr, rd, add, data_in, output data_out, rd_valid, init_busy);
endinterface

// File: rtl/ram_init_seq.sv
// ram_init_seq: zeroing sweep counter and INIT/RUN FSM for ram_sync_param
module ram_init_seq
  import ram_sync_param_pkg::*;
#(
  parameter int ADDR_W = 3,
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic init_busy,
  output logic init_we,
  output logic [ADDR_W-1:0] init_addr
);
  // One extra bit so DEPTH == 2**ADDR_W never wraps the counter
  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH-1);
  logic [0:0] state;
  logic [ADDR_W:0] cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_INIT;
      cnt <= '0;
    end else if (clr) begin
      state <= ST_INIT;
      cnt <= '0;
    end else if (state == ST_INIT) begin
      state <= (cnt == LAST) ? ST_RUN : ST_INIT;
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end
  assign init_busy = (state == ST_INIT);
  assign init_we = init_busy;
  assign init_addr = cnt[ADDR_W-1:0];
endmodule

// File: rtl/ram_sync_param.sv
// ram_sync_param: single-port synchronous RAM with zeroing sweep and optional output register
module ram_sync_param
  import ram_sync_param_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 3,
  parameter int DEPTH = 8,
  parameter int RD_MODE = 0,
  parameter int OUT_REG = 0
) (
  input logic clk,
  input logic rst_n,
  ram_if.slave bus
);
  localparam logic [ADDR_W:0] LIM = (ADDR_W+1)'(DEPTH);
  logic [DATA_W-1:0] mem [DEPTH];
  logic init_we, busy, in_range, acc, p_valid;
  logic [ADDR_W-1:0] init_addr;
  logic [DATA_W-1:0] rd_word, p_data;
  ram_init_seq #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_seq (
    .clk(clk),
    .rst_n(rst_n),
    .clr(bus.clr),
    .init_busy(busy),
    .init_we(init_we),
    .init_addr(init_addr)
  );
  assign bus.init_busy = busy;
  always_comb begin
    in_range = {1'b0, bus.add} < LIM;
    acc = bus.rd && !busy;
    rd_word = !in_range ? '0 : (RD_MODE == WR_FIRST && bus.wr) ? bus.data_in : mem[bus.add];
  end
  always_ff @(posedge clk) begin
    if (init_we) mem[init_addr] <= '0;
    else if (bus.wr && in_range) mem[bus.add] <= bus.data_in;
  end
  if (OUT_REG != 0) begin : g_reg
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        p_valid <= 1'b0;
        p_data <= '0;
      end else begin
        p_valid <= acc;
        if (acc) p_data <= rd_word;
      end
    end
  end else begin : g_noreg
    assign p_valid = acc;
    assign p_data = rd_word;
  end
  // Final stage is not gated by busy so reads already in flight still land
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rd_valid <= 1'b0;
      bus.data_out <= '0;
    end else begin
      bus.rd_valid <= p_valid;
      if (p_valid) bus.data_out <= p_data;
    end
  end
endmodule

// File: tb/tb_ram_sync_param.sv
// tb_ram_sync_param: four RAM configurations on shared random stimulus against a cycle-level model
module tb_ram_sync_param;
  import ram_sync_param_pkg::*;
  logic clk = 1'b0, rst_n = 1'b1, clr = 1'b0, wr = 1'b0, rd = 1'b0;
  logic [2:0] add = '0;
  logic [3:0] din = '0;
  logic [3:0][3:0] dout;
  logic [3:0] vld, busy;
  int checks = 0, errors = 0;
  int e = 0;
  int init_left [4];
  logic [3:0] mm [4][8];
  logic sv [4][4];
  logic [3:0] sd [4][4];
  logic [3:0] ed [4];
  always #15 clk = ~clk;
  for (genvar g = 0; g < 4; g++) begin : u
    ram_if #(.DATA_W(4), .ADDR_W(3)) b ();
    assign b.clr = clr;
    assign b.wr = wr;
    assign b.rd = rd;
    assign b.add = add;
    assign b.data_in = din;
    ram_sync_param #(
      .DATA_W(4), .ADDR_W(3), .DEPTH(g < 2 ? 8 : 6),
      .RD_MODE(g % 2), .OUT_REG((g == 1 || g == 2) ? 1 : 0)
    ) dut (.clk(clk), .rst_n(rst_n), .bus(b));
    assign dout[g] = b.data_out;
    assign vld[g] = b.rd_valid;
    assign busy[g] = b.init_busy;
  end
  function automatic int dep(input int c);
    return c < 2 ? 8 : 6;
  endfunction
  function automatic int lat(input int c);
    return (c == 1 || c == 2) ? 2 : 1;
  endfunction
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic do_reset();
    clr = 0; wr = 0; rd = 0;
    #3 rst_n = 1'b0;
    #1;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("c%0d_rst_busy", c), int'(busy[c]), 1);
      chk($sformatf("c%0d_rst_valid", c), int'(vld[c]), 0);
      chk($sformatf("c%0d_rst_dout", c), int'(dout[c]), 0);
      init_left[c] = dep(c);
      ed[c] = '0;
      for (int s = 0; s < 4; s++) sv[c][s] = 1'b0;
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic step(input logic c_clr, input logic w, input logic r, input logic [2:0] a, input logic [3:0] d);
    clr = c_clr; wr = w; rd = r; add = a; din = d;
    @(posedge clk);
    e++;
    for (int c = 0; c < 4; c++) begin
      if (init_left[c] > 0) begin
        init_left[c]--;
        if (init_left[c] == 0) for (int k = 0; k < 8; k++) mm[c][k] = '0;
      end else begin
        if (r) begin
          sv[c][(e + lat(c) - 1) % 4] = 1'b1;
          sd[c][(e + lat(c) - 1) % 4] = (int'(a) >= dep(c)) ? 4'h0 : ((c % 2 == WR_FIRST) && w) ? d : mm[c][a];
        end
        if (w && int'(a) < dep(c)) mm[c][a] = d;
      end
      if (c_clr) init_left[c] = dep(c);
    end
    @(negedge clk);
    for (int c = 0; c < 4; c++) begin
      if (sv[c][e % 4]) ed[c] = sd[c][e % 4];
      chk($sformatf("c%0d_valid@%0d", c, e), int'(vld[c]), int'(sv[c][e % 4]));
      chk($sformatf("c%0d_dout@%0d", c, e), int'(dout[c]), int'(ed[c]));
      chk($sformatf("c%0d_busy@%0d", c, e), int'(busy[c]), int'(init_left[c] > 0));
      sv[c][e % 4] = 1'b0;
    end
  endtask
  initial begin
    do_reset();
    repeat (9) step(0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 3'(i), 0);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 3'(i), 4'(i));
    for (int i = 0; i < 4; i++) step(0, 0, 1, 3'(i), 0);
    repeat (2) step(0, 0, 0, 0, 0);
    step(0, 1, 0, 5, 4'hA);
    step(0, 1, 1, 5, 4'h6);
    step(0, 0, 1, 5, 0);
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 7, 4'hF);
    step(0, 0, 1, 7, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 1, 3'(i), 0);
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 1, 3'(i), 4'hF);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 3'(i), 0);
    repeat (2) step(0, 0, 0, 0, 0);
    step(0, 1, 0, 2, 4'h9);
    step(0, 0, 1, 2, 0);
    do_reset();
    repeat (10) step(0, 0, 0, 0, 0);
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 149) == 0) do_reset();
      step($urandom_range(0, 39) == 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
    end
    repeat (3) step(0, 0, 0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
